// File: rtl/timer_pkg.sv
// Shared definitions for the timer: FSM states, register word offsets,
// CTRL bit positions and Mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Only the exact auto-reload code reloads; every other Mode value is one-shot.
  function automatic logic is_auto_reload(input logic [3:0] ctrl);
    return ctrl[CTRL_MODE_LSB +: 2] == MODE_AUTO;
  endfunction

endpackage

// File: rtl/timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Three bus-visible words: CTRL, PRESET, COUNT.
module timer
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  timer_state_e state_reg, state_next;
  logic [3:0]   ctrl_reg, ctrl_next;
  logic [31:0]  preset_reg, preset_next;
  logic [31:0]  count_reg, count_next;
  logic         pend_reg, pend_next;

  logic enable;
  assign enable = ctrl_reg[CTRL_EN_BIT];

  always_comb begin
    state_next  = state_reg;
    ctrl_next   = ctrl_reg;
    preset_next = preset_reg;
    count_next  = count_reg;
    pend_next   = pend_reg;

    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        count_next = preset_reg;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (count_reg <= 32'd1) begin
          // Saturate at zero so PRESET=0 behaves like PRESET=1.
          count_next = 32'd0;
          pend_next  = 1'b1;
          state_next = ST_INT;
        end else begin
          count_next = count_reg - 32'd1;
        end
      end
      ST_INT: begin
        if (is_auto_reload(ctrl_reg)) pend_next = 1'b0;
        else                          ctrl_next[CTRL_EN_BIT] = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // CPU writes are applied last so they override any FSM update.
    if (WE) begin
      case (Addr)
        ADDR_CTRL: begin
          ctrl_next = DIn[3:0];
          pend_next = 1'b0;
        end
        ADDR_PRESET: begin
          preset_next = DIn;
          pend_next   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      ctrl_reg   <= 4'h0;
      preset_reg <= PRESET_RST;
      count_reg  <= 32'h0;
      pend_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctrl_reg   <= ctrl_next;
      preset_reg <= preset_next;
      count_reg  <= count_next;
      pend_reg   <= pend_next;
    end
  end

  always_comb begin
    DOut = 32'h0;
    case (Addr)
      ADDR_CTRL:   DOut = {28'h0, ctrl_reg};
      ADDR_PRESET: DOut = preset_reg;
      ADDR_COUNT:  DOut = count_reg;
      default:     DOut = 32'h0;
    endcase
  end

  assign IRQ = ctrl_reg[CTRL_IM_BIT] & pend_reg;

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port Addr, input, 2 bits: word select, where 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-004 The block SHALL have the port WE, input, 1 bit: write enable from the system bridge.
REQ-005 The block SHALL have the port DIn, input, 32 bits: write data.
REQ-006 The block SHALL have the port DOut, output, 32 bits: combinational read data for Addr.
REQ-007 The block SHALL have the port IRQ, output, 1 bit: interrupt request, wired to one HWInt bit of the coprocessor-0 interrupt input.
REQ-008 The block SHALL have the parameter PRESET_RST, default 32'h0: reset value of PRESET.

Function
REQ-009 CTRL SHALL hold 4 bits: [0] Enable, [2:1] Mode (00 = one-shot, 01 = auto-reload, 1x = treated as one-shot), [3] IM (interrupt mask); bits [31:4] SHALL read 0 and ignore writes.
REQ-010 A write with WE=1 SHALL update the addressed register at the clock edge; writes to COUNT or Addr=3 SHALL be ignored.
REQ-011 DOut SHALL present the addressed register with zero latency; Addr=3 SHALL read 0.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-013 IDLE: if Enable=1 the FSM SHALL go to LOAD, else it SHALL stay in IDLE.
REQ-014 LOAD: the block SHALL set COUNT <= PRESET and go to CNT.
REQ-015 CNT with Enable=0: the FSM SHALL go to IDLE and hold COUNT.
REQ-016 CNT with Enable=1 and COUNT<=1: the block SHALL set COUNT <= 0, set pend <= 1 and go to INT.
REQ-017 CNT with Enable=1 and COUNT>1: the block SHALL set COUNT <= COUNT-1 and stay in CNT.
REQ-018 INT in one-shot mode: the block SHALL clear Enable and go to IDLE; pend SHALL stay 1 until a CPU write to CTRL or PRESET.
REQ-019 INT in auto-reload mode: the block SHALL clear pend and go to IDLE; Enable stays 1, so the FSM reloads via LOAD.
REQ-020 IRQ SHALL equal IM & pend, combinationally; auto-reload therefore gives exactly a 1-cycle IRQ pulse per period.
REQ-021 Latency: with the Enable write at edge E0 and PRESET=N>=1, COUNT SHALL be N at E2 and the FSM SHALL enter INT at edge E(2+N); the period in auto-reload mode SHALL be N+3 cycles.
REQ-022 PRESET=0 SHALL behave identically to PRESET=1.
REQ-023 When a CPU write to CTRL coincides with an FSM update of Enable in INT, the CPU write SHALL win.
REQ-024 A PRESET write during CNT SHALL not change COUNT until the next LOAD.
REQ-025 A write clearing Enable during CNT SHALL freeze COUNT at the next edge.
REQ-026 COUNT SHALL never wrap below 0.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL force CTRL=0, PRESET=PRESET_RST, COUNT=0, pend=0 and state=IDLE, overriding any concurrent write or count step.
REQ-028 Following reset, IRQ=0 and DOut SHALL reflect the reset register values.
REQ-029 Reset asserted mid-count SHALL abort the count with no IRQ.

Structure
REQ-030 State encodings, register word offsets, CTRL bit positions and Mode codes SHALL live in the shared macro header.
REQ-031 The block SHALL be single-level with no sub-modules.

Verification
REQ-032 One-shot: PRESET=3, CTRL=0x9 -> COUNT reads 3,2,1,0; IRQ=1 at E5 and held; Enable reads 0; writing CTRL=0x9 clears IRQ.
REQ-033 Auto-reload: PRESET=2, CTRL=0xB -> IRQ pulses 1 cycle, repeating every 5 cycles, for at least 3 periods.
REQ-034 Mask: PRESET=2, CTRL=0x1 -> state reaches INT, IRQ stays 0; a later CTRL=0x9 write leaves pend cleared and IRQ 0.
REQ-035 Pause: PRESET=10, enable, at COUNT=6 write CTRL=0x8 -> COUNT frozen at 5; re-enable -> reload to 10.
REQ-036 Reset mid-count: PRESET=8, COUNT=4, reset pulse for 1 cycle -> all registers 0, IRQ 0, COUNT stays 0.
REQ-037 Edge case: PRESET=0, CTRL=0x9 -> INT at E3, same as PRESET=1; a COUNT write is ignored.
